// File: rtl/rfsoc_config_pkg.sv
// Shared constants and types for the RFSoC DAC datapath blocks.
// The waveform buffer packs 32-bit DMA beats into 256-bit DAC words.
package rfsoc_config;

    localparam int WAVE_WORD_W         = 256;
    localparam int WAVE_BEAT_W         = 32;
    localparam int WAVE_BEATS_PER_WORD = 8;

    typedef enum logic [1:0] {
        WB_EMPTY,
        WB_LOAD,
        WB_PRIME,
        WB_PLAY
    } wave_buffer_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
// rdata holds its last value while re is low.
module sdp_ram #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/wave_buffer.sv
// Waveform buffer: packs DMA beats into 256-bit words in RAM and replays them to the DAC.
// WAVE_BUFFER_LOOP_EN defined: looping playback; undefined: one-shot playback then zeros.
module wave_buffer
    import rfsoc_config::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WAVE_BEAT_W-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [WAVE_WORD_W-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    input  logic                   clear,
    input  logic                   rewind,
    output logic [ADDR_W:0]        word_count,
    output logic                   loaded,
    output logic                   overflow,
    output logic [1:0]             dbg_state
);

    localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);
    localparam logic [2:0]      LAST_BEAT = 3'(WAVE_BEATS_PER_WORD - 1);

    // Both streams: a transfer happens on the rising edge where tvalid and tready are
    // both high; tvalid never waits on tready, and m_axis_tdata holds while tvalid & !tready.

    wave_buffer_state_t state, state_next;
    logic issue_state;

    logic                   s_hs, word_done;
    logic [2:0]             beat_idx;
    logic [WAVE_WORD_W-1:0] stage, stage_next;
    logic [ADDR_W:0]        wr_ptr, rd_ptr, rd_ptr_next, word_count_q;
    logic                   wr_en_q, overflow_q;
    logic [ADDR_W-1:0]      wr_addr_q;
    logic [WAVE_WORD_W-1:0] wr_data_q;

    logic                   out_valid, skid_valid, ram_valid;
    logic [WAVE_WORD_W-1:0] out_data, skid_data, ram_q, ram_data;
    logic                   rd_en, rd_zero_q, rd_zero_next, rd_bypass_q, rd_bypass_next;
    logic                   out_free, ram_drained;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WB_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = WB_EMPTY;
        end else begin
            case (state)
                WB_EMPTY: if (s_hs) state_next = s_axis_tlast ? WB_PRIME : WB_LOAD;
                WB_LOAD:  if (s_hs && s_axis_tlast) state_next = WB_PRIME;
                WB_PRIME: if (!rewind && out_valid) state_next = WB_PLAY;
                WB_PLAY:  if (rewind) state_next = WB_PRIME;
                default:  state_next = WB_EMPTY;
            endcase
        end
    end

    always_comb begin
        s_axis_tready = !rst && (state == WB_EMPTY || state == WB_LOAD);
        loaded        = (state == WB_PRIME || state == WB_PLAY);
        issue_state   = loaded;
        dbg_state     = state;
    end

    // ---------------- beat packing and RAM write ----------------
    assign s_hs      = s_axis_tvalid && s_axis_tready;
    assign word_done = s_hs && (beat_idx == LAST_BEAT || s_axis_tlast);

    always_comb begin
        stage_next = stage;
        stage_next[{beat_idx, 5'd0} +: WAVE_BEAT_W] = s_axis_tdata;
    end

    // The staging word is zeroed after every write, so a short final word is zero-padded.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            beat_idx     <= '0;
            stage        <= '0;
            wr_ptr       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (s_hs) begin
                if (word_done) begin
                    stage    <= '0;
                    beat_idx <= '0;
                    if (wr_ptr == DEPTH_W) begin
                        overflow_q <= 1'b1;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= wr_ptr[ADDR_W-1:0];
                        wr_data_q <= stage_next;
                        wr_ptr    <= wr_ptr + ONE;
                    end
                    if (s_axis_tlast) begin
                        word_count_q <= (wr_ptr == DEPTH_W) ? DEPTH_W : wr_ptr + ONE;
                    end
                end else begin
                    stage    <= stage_next;
                    beat_idx <= beat_idx + 3'd1;
                end
            end
        end
    end

    sdp_ram #(
        .WIDTH(WAVE_WORD_W),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en_q),
        .waddr(wr_addr_q),
        .wdata(wr_data_q),
        .re   (rd_en),
        .raddr(rd_ptr[ADDR_W-1:0]),
        .rdata(ram_q)
    );

    // ---------------- read issue and prefetch ----------------
    always_comb begin
`ifdef WAVE_BUFFER_LOOP_EN
        rd_zero_next = 1'b0;
        rd_ptr_next  = (rd_ptr == word_count_q - ONE) ? '0 : rd_ptr + ONE;
`else
        rd_zero_next = (rd_ptr >= word_count_q);
        rd_ptr_next  = rd_zero_next ? rd_ptr : rd_ptr + ONE;
`endif
        // The last word is written on the first PRIME edge, when address 0 may also be read.
        rd_bypass_next = wr_en_q && (wr_addr_q == rd_ptr[ADDR_W-1:0]);
    end

    // RAM output register is the third slot; a read is issued only when a slot is sure to be free.
    assign rd_en       = issue_state && !clear && !rewind && !(out_valid && skid_valid && ram_valid);
    assign ram_data    = rd_zero_q ? '0 : (rd_bypass_q ? wr_data_q : ram_q);
    assign out_free    = !out_valid || m_axis_tready;
    assign ram_drained = ram_valid && (out_free || !skid_valid);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            ram_valid   <= 1'b0;
            rd_ptr      <= '0;
            rd_zero_q   <= 1'b0;
            rd_bypass_q <= 1'b0;
        end else if (rewind && loaded) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            ram_valid  <= 1'b0;
            rd_ptr     <= '0;
        end else begin
            if (out_free) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    skid_valid <= ram_valid;
                    if (ram_valid) skid_data <= ram_data;
                end else if (ram_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= ram_data;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (!skid_valid && ram_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= ram_data;
            end
            ram_valid <= rd_en || (ram_valid && !ram_drained);
            if (rd_en) begin
                rd_ptr      <= rd_ptr_next;
                rd_zero_q   <= rd_zero_next;
                rd_bypass_q <= rd_bypass_next;
            end
        end
    end

    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = out_data;
    assign word_count    = word_count_q;
    assign overflow      = overflow_q;

endmodule
